mem_rw_arbiter: RTL
===================

Name: mem_rw_arbiter

Overview:
Shares the single read/write memory port (mem_rwport) between several masters: core LSU, front-panel examine/deposit, and stdin loader. It uses locked round-robin arbitration with a val/rdy handshake on both sides. A grant is held until the memory completes the transaction. A watchdog aborts any transaction the memory never acknowledges.

Parameters:
NREQ, 3, number of requesters (2..8); index 0 = core LSU.
AW, 8, address width.
DW, 16, data width.
TIMEOUT, 255, max BUSY cycles without mem_rdy_i before abort (1..65535).

Ports:
clk_i  in  1  clock, rising edge.
arst_i  in  1  asynchronous reset, active-high.
req_val_i  in  NREQ  per-requester request valid.
req_wen_i  in  NREQ  per-requester write enable (1 = write).
req_addr_i  in  NREQ*AW  packed addresses; requester k at [k*AW +: AW].
req_wdata_i  in  NREQ*DW  packed write data; requester k at [k*DW +: DW].
req_rdy_o  out  NREQ  per-requester completion strobe.
req_rdata_o  out  DW  read data, broadcast to all requesters.
mem_val_o  out  1  memory request valid.
mem_wen_o  out  1  memory write enable.
mem_addr_o  out  AW  memory address.
mem_wdata_o  out  DW  memory write data.
mem_rdy_i  in  1  memory accept/complete; rdata is valid in the same cycle.
mem_rdata_i  in  DW  memory read data.
grant_o  out  NREQ  one-hot registered grant; all zero in IDLE.
busy_o  out  1  state == BUSY.
timeout_o  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (arst_i = 1, asynchronous):
  - state = IDLE, grant_o = 0, rr pointer = 0, watchdog = 0, timeout_o = 0.
  - All mem_* outputs and req_rdy_o are 0 while reset is asserted.
  - Reset mid-transaction drops mem_val_o immediately. No completion strobe is issued.
- State IDLE:
  - mem_val_o = 0.
  - If req_val_i != 0, the winner is the first set bit scanning from the rr pointer upward, wrapping NREQ-1 -> 0.
  - Next cycle: grant_o = onehot(winner), state = BUSY, watchdog cleared.
  - Arbitration latency is exactly 1 cycle.
- State BUSY, granted index g:
  - mem_val_o = req_val_i[g].
  - mem_wen_o, mem_addr_o, mem_wdata_o = requester g's fields, combinational pass-through.
  - Requesters must hold their fields stable while val is high and rdy is low.
- Completion (BUSY and mem_val_o and mem_rdy_i):
  - Same cycle: req_rdy_o[g] = 1 and req_rdata_o = mem_rdata_i.
  - Next cycle: rr pointer = (g+1) mod NREQ, state = IDLE, grant_o = 0.
  - Minimum cost is 2 cycles per transaction.
  - No two requesters are ever strobed in the same cycle.
- req_rdy_o:
  - req_rdy_o[k] = 0 whenever grant_o[k] = 0.
  - req_rdy_o[g] = mem_rdy_i while BUSY, so a granted requester sees a zero-cycle combinational path from mem_rdy_i.
- req_rdata_o: equals mem_rdata_i at all times (broadcast). Requesters qualify it with req_rdy_o.
- Withdrawal: if req_val_i[g] drops while BUSY without completion, the state returns to IDLE next cycle. The rr pointer is unchanged and no strobe is issued.
- Watchdog:
  - Increments each BUSY cycle without completion.
  - On reaching TIMEOUT: timeout_o = 1 for one cycle, state goes to IDLE next cycle, and rr advances past g so a hung requester cannot starve others.
  - Saturating, width clog2(TIMEOUT+1).
- Fairness: any requester holding val continuously is granted within NREQ-1 other transactions.
- The grant is locked: a request arriving during BUSY never preempts, even from index 0.
- busy_o = (state == BUSY), registered.

Test Plan:
- Single read: reset, req_val_i = 001, req_wen_i = 0, addr0 = 8'h20, memory returns 16'hBEEF with rdy 2 cycles after mem_val_o -> grant_o = 001 at t+1; req_rdy_o[0] pulses once with req_rdata_o = BEEF; back to IDLE 1 cycle later.
- Round-robin: req_val_i = 111 held, memory rdy immediately -> grant order 0, 1, 2, 0, 1, 2; each req_rdy_o strobe 2 cycles apart.
- Write pass-through: requester 2 writes addr 8'hFF, data 16'h1234 -> mem_wen_o = 1, mem_addr_o = FF, mem_wdata_o = 1234 exactly while grant_o = 100; other requesters' req_rdy_o stay 0.
- Timeout: TIMEOUT = 4, requester 1 requests, mem_rdy_i held 0 -> timeout_o pulses after 4 BUSY cycles; IDLE next cycle; a pending requester 2 is granted next; req_rdy_o[1] never asserted.
- Async reset mid-BUSY: assert arst_i between clock edges during a grant -> mem_val_o, grant_o, busy_o drop to 0 without waiting for an edge; after release, the first grant goes to the lowest pending index (pointer = 0).
- Withdrawal: requester 0 granted, req_val_i[0] drops before rdy -> mem_val_o = 0 the same cycle; IDLE next; the rr pointer still selects 0 first when it re-requests alongside 1.

Source files
------------

// File: rtl/mem_rw_arbiter.sv
// Locked round-robin arbiter sharing one read/write memory port between NREQ masters,
// with a val/rdy handshake on both sides and a watchdog that aborts unacknowledged accesses.
module mem_rw_arbiter #(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic [NREQ-1:0]      req_val_i,
  input  logic [NREQ-1:0]      req_wen_i,
  input  logic [NREQ*AW-1:0]   req_addr_i,
  input  logic [NREQ*DW-1:0]   req_wdata_i,
  output logic [NREQ-1:0]      req_rdy_o,
  output logic [DW-1:0]        req_rdata_o,
  output logic                 mem_val_o,
  output logic                 mem_wen_o,
  output logic [AW-1:0]        mem_addr_o,
  output logic [DW-1:0]        mem_wdata_o,
  input  logic                 mem_rdy_i,
  input  logic [DW-1:0]        mem_rdata_i,
  output logic [NREQ-1:0]      grant_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  localparam logic [WW-1:0] WdLast = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WdMax  = WW'(TIMEOUT);

  logic [0:0]      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [WW-1:0]   wd_q, wd_d;

  logic            busy;
  logic            complete;
  logic            wd_fire;
  logic [IW-1:0]   gidx;
  logic [IW-1:0]   g_next;
  logic            sel_val;
  logic            sel_wen;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  logic [2*NREQ-1:0] val_dbl;
  logic [NREQ-1:0]   val_rot;
  logic [IW-1:0]     win_idx;
  logic              win_found;
  int unsigned       win_pos;

  // Granted requester's fields; all zero when nothing is granted.
  always_comb begin
    gidx      = '0;
    sel_val   = 1'b0;
    sel_wen   = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_q[k]) begin
        gidx      = IW'(k);
        sel_val   = sel_val | req_val_i[k];
        sel_wen   = sel_wen | req_wen_i[k];
        sel_addr  = sel_addr | req_addr_i[k*AW +: AW];
        sel_wdata = sel_wdata | req_wdata_i[k*DW +: DW];
      end
    end
  end

  assign busy     = (state_q == StBusy);
  assign complete = busy & sel_val & mem_rdy_i;
  assign wd_fire  = busy & ~complete & (wd_q == WdLast);
  assign g_next   = (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);

  // Rotate requests so bit 0 is the rr pointer, then take the first set bit.
  always_comb begin
    val_dbl   = {req_val_i, req_val_i};
    val_rot   = NREQ'(val_dbl >> rr_q);
    win_found = 1'b0;
    win_pos   = 0;
    win_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && val_rot[i]) begin
        win_found = 1'b1;
        win_pos   = int'(rr_q) + i;
        if (win_pos >= NREQ) win_pos = win_pos - NREQ;
      end
    end
    win_idx = IW'(win_pos);
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    wd_d    = wd_q;
    if (state_q == StIdle) begin
      if (win_found) begin
        state_d = StBusy;
        grant_d = NREQ'(1) << win_idx;
        wd_d    = '0;
      end
    end else begin
      if (complete || wd_fire) begin
        state_d = StIdle;
        grant_d = '0;
        rr_d    = g_next;
      end else if (!sel_val) begin
        // Withdrawn request: release without moving the pointer.
        state_d = StIdle;
        grant_d = '0;
      end else begin
        wd_d = (wd_q == WdMax) ? wd_q : wd_q + WW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= StIdle;
      grant_q <= '0;
      rr_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      wd_q    <= wd_d;
    end
  end

  assign mem_val_o   = busy & sel_val;
  assign mem_wen_o   = sel_wen;
  assign mem_addr_o  = sel_addr;
  assign mem_wdata_o = sel_wdata;
  assign req_rdy_o   = grant_q & {NREQ{complete}};
  assign req_rdata_o = mem_rdata_i;
  assign grant_o     = grant_q;
  assign busy_o      = busy;
  assign timeout_o   = wd_fire;

endmodule
